// File: rtl/sync_fifo_param_if.sv
// Handshake/data bundle between a FIFO user (master) and sync_fifo_param (slave).
interface sync_fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             wr;
  logic [WIDTH-1:0] din;
  logic             rd;
  logic             clr_err;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, wr, din, rd, clr_err,
    input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wr, din, rd, clr_err,
    output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with first-word-fall-through read, occupancy
// count, almost-full/almost-empty thresholds, flush and sticky error flags.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1
) (
  input logic              clk,
  input logic              reset,
  sync_fifo_param_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [CW-1:0]    count_r, count_nxt_s;
  logic             overflow_r, underflow_r, overflow_nxt_s, underflow_nxt_s;
  logic             full_s, empty_s, wr_acc_s, rd_acc_s;

  // Pointers wrap at DEPTH-1 so non-power-of-two depths never touch unused slots.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign full_s  = (count_r == CW'(DEPTH));
  assign empty_s = (count_r == {CW{1'b0}});

  // Accept decisions and next state, all from pre-edge registered state.
  always_comb begin
    wr_acc_s        = 1'b0;
    rd_acc_s        = 1'b0;
    wr_ptr_nxt_s    = wr_ptr_r;
    rd_ptr_nxt_s    = rd_ptr_r;
    count_nxt_s     = count_r;
    overflow_nxt_s  = overflow_r & ~bus.clr_err;
    underflow_nxt_s = underflow_r & ~bus.clr_err;
    if (bus.flush) begin
      wr_ptr_nxt_s = {PW{1'b0}};
      rd_ptr_nxt_s = {PW{1'b0}};
      count_nxt_s  = {CW{1'b0}};
    end else begin
      wr_acc_s        = bus.wr & ~full_s;
      rd_acc_s        = bus.rd & ~empty_s;
      wr_ptr_nxt_s    = wr_acc_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
      rd_ptr_nxt_s    = rd_acc_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
      overflow_nxt_s  = overflow_nxt_s | (bus.wr & full_s);
      underflow_nxt_s = underflow_nxt_s | (bus.rd & empty_s);
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_nxt_s = count_r + CW'(1);
        2'b01:   count_nxt_s = count_r - CW'(1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      overflow_r  <= overflow_nxt_s;
      underflow_r <= underflow_nxt_s;
    end
  end

  // Storage array; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (wr_acc_s && !reset) begin
      mem_r[wr_ptr_r] <= bus.din;
    end
  end

  assign bus.dout         = empty_s ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
  assign bus.full         = full_s;
  assign bus.empty        = empty_s;
  assign bus.almost_full  = (count_r >= CW'(AF_LEVEL));
  assign bus.almost_empty = (count_r <= CW'(AE_LEVEL));
  assign bus.count        = count_r;
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: two instances (DEPTH=8 and DEPTH=5) driven by
// directed and random traffic, compared against a queue-based model.
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic rst8, rst5;
  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] q8[$];
  logic [7:0] q5[$];
  bit ov8 = 1'b0, un8 = 1'b0, ov5 = 1'b0, un5 = 1'b0;

  sync_fifo_param_if #(.WIDTH(8), .DEPTH(8)) if8 ();
  sync_fifo_param_if #(.WIDTH(8), .DEPTH(5)) if5 ();

  sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1)) u_dut8 (
    .clk(clk), .reset(rst8), .bus(if8.slave)
  );
  sync_fifo_param #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u_dut5 (
    .clk(clk), .reset(rst5), .bus(if5.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // One clock on the selected instance; the other sees idle inputs and holds state.
  task automatic cyc(input int sel, input bit rst, input bit fl, input bit w, input bit r,
                     input logic [7:0] d, input bit ce);
    int depth, afl, sz;
    bit full_m, empty_m, ov, un;
    logic [7:0] head;
    logic [31:0] o_cnt;
    logic o_full, o_empty, o_af, o_ae, o_ov, o_un;
    logic [7:0] o_dout;
    string nm;
    rst8 = 1'b0; if8.flush = 1'b0; if8.wr = 1'b0; if8.rd = 1'b0; if8.din = 8'h00; if8.clr_err = 1'b0;
    rst5 = 1'b0; if5.flush = 1'b0; if5.wr = 1'b0; if5.rd = 1'b0; if5.din = 8'h00; if5.clr_err = 1'b0;
    if (sel == 0) begin
      rst8 = rst; if8.flush = fl; if8.wr = w; if8.rd = r; if8.din = d; if8.clr_err = ce;
    end else begin
      rst5 = rst; if5.flush = fl; if5.wr = w; if5.rd = r; if5.din = d; if5.clr_err = ce;
    end
    depth = (sel == 0) ? 8 : 5;
    afl   = (sel == 0) ? 6 : 4;
    sz    = (sel == 0) ? q8.size() : q5.size();
    ov    = (sel == 0) ? ov8 : ov5;
    un    = (sel == 0) ? un8 : un5;
    full_m  = (sz == depth);
    empty_m = (sz == 0);
    @(posedge clk);
    if (rst) begin
      if (sel == 0) q8.delete(); else q5.delete();
      ov = 1'b0; un = 1'b0;
    end else if (fl) begin
      if (sel == 0) q8.delete(); else q5.delete();
      ov = ov && !ce; un = un && !ce;
    end else begin
      if (r && !empty_m) begin
        if (sel == 0) void'(q8.pop_front()); else void'(q5.pop_front());
      end
      if (w && !full_m) begin
        if (sel == 0) q8.push_back(d); else q5.push_back(d);
      end
      ov = (ov && !ce) || (w && full_m);
      un = (un && !ce) || (r && empty_m);
    end
    if (sel == 0) begin ov8 = ov; un8 = un; end else begin ov5 = ov; un5 = un; end
    #1;
    sz = (sel == 0) ? q8.size() : q5.size();
    head = 8'h00;
    if (sz > 0) head = (sel == 0) ? q8[0] : q5[0];
    if (sel == 0) begin
      nm = "d8"; o_cnt = 32'(if8.count); o_full = if8.full; o_empty = if8.empty;
      o_af = if8.almost_full; o_ae = if8.almost_empty; o_ov = if8.overflow;
      o_un = if8.underflow; o_dout = if8.dout;
    end else begin
      nm = "d5"; o_cnt = 32'(if5.count); o_full = if5.full; o_empty = if5.empty;
      o_af = if5.almost_full; o_ae = if5.almost_empty; o_ov = if5.overflow;
      o_un = if5.underflow; o_dout = if5.dout;
    end
    check({nm, "_count"}, o_cnt, 32'(sz));
    check({nm, "_full"}, 32'(o_full), 32'(sz == depth));
    check({nm, "_empty"}, 32'(o_empty), 32'(sz == 0));
    check({nm, "_afull"}, 32'(o_af), 32'(sz >= afl));
    check({nm, "_aempty"}, 32'(o_ae), 32'(sz <= 1));
    check({nm, "_dout"}, 32'(o_dout), 32'(head));
    check({nm, "_ovf"}, 32'(o_ov), 32'(ov));
    check({nm, "_unf"}, 32'(o_un), 32'(un));
  endtask

  initial begin
    int wp;
    bit w, r, fl, ce, rs;
    rst8 = 1'b1; rst5 = 1'b1;
    if8.flush = 1'b0; if8.wr = 1'b0; if8.rd = 1'b0; if8.din = 8'h00; if8.clr_err = 1'b0;
    if5.flush = 1'b0; if5.wr = 1'b0; if5.rd = 1'b0; if5.din = 8'h00; if5.clr_err = 1'b0;
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // fill to full, overflow, drain
    for (int i = 1; i <= 8; i++) cyc(0, 1'b0, 1'b0, 1'b1, 1'b0, 8'(i), 1'b0);
    cyc(0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0);
    for (int i = 0; i < 9; i++) cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    // simultaneous wr/rd on empty, then clear errors
    cyc(0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    // full + wr + rd: read accepted, write rejected
    for (int i = 0; i < 7; i++) cyc(0, 1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    cyc(0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hEE, 1'b0);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    // flush with wr/rd asserted, then write/read back
    cyc(0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h77, 1'b0);
    cyc(0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 1'b0);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    // mid-operation reset at count 5 with overflow set
    for (int i = 0; i < 9; i++) cyc(0, 1'b0, 1'b0, 1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
    for (int i = 0; i < 3; i++) cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    cyc(0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 1'b0);

    // wrap on DEPTH=5 at steady count 3
    for (int i = 0; i < 3; i++) cyc(1, 1'b0, 1'b0, 1'b1, 1'b0, 8'(i), 1'b0);
    for (int i = 3; i < 23; i++) cyc(1, 1'b0, 1'b0, 1'b1, 1'b1, 8'(i), 1'b0);

    // random traffic with periodically shifting write bias
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 1500; i++) begin
        if ((i % 64) == 0) wp = 20 + 30 * int'($urandom_range(0, 2));
        w  = ($urandom_range(0, 99) < wp);
        r  = ($urandom_range(0, 99) < 50);
        fl = ($urandom_range(0, 99) < 2);
        ce = !fl && ($urandom_range(0, 99) < 5);
        rs = ($urandom_range(0, 999) < 5);
        cyc(s, rs, fl, w, r, 8'($urandom), ce);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
